// File: rtl/rs_msg_framer.sv
// rs_msg_framer: buffers a valid/ready byte stream in a FIFO and hands it to
// the RS(255,251) encoder as gap-free KK-byte bursts (sop on beat 0, eop on
// beat KK-1). A flush pulse sends whatever is pending, padded with PAD_BYTE.
module rs_msg_framer #(
  parameter int          KK       = 251,
  parameter int          DEPTH    = 512,
  parameter int          AW       = 9,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          flush,
  input  logic          enc_busy,
  output logic          din_val,
  output logic          din_sop,
  output logic          din_eop,
  output logic [7:0]    din,
  output logic [AW:0]   level,
  output logic [15:0]   msg_cnt,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW:0] KK_L      = (AW+1)'(KK);
  localparam logic [7:0]  KK_B      = 8'(KK);
  localparam logic [7:0]  LAST_BEAT = 8'(KK - 1);

  // Handshake: a byte moves on any clock edge where s_valid and s_ready are
  // both high; s_ready depends only on the registered level, never on s_valid.

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;

  state_t        r_state;
  logic [7:0]    r_beat;
  logic [7:0]    r_real;
  logic          r_flush_pend;
  logic          r_din_val;
  logic          r_din_sop;
  logic          r_din_eop;
  logic [7:0]    r_din;
  logic [15:0]   r_msg_cnt;

  logic          w_not_full;
  logic          w_wr;
  logic          w_rd;
  logic          w_start;
  logic          w_pop_send;
  logic [7:0]    w_next_beat;
  logic [7:0]    w_real;
  logic [7:0]    w_rd_data;

  assign w_not_full  = (r_level != DEPTH_L);
  assign w_wr        = s_valid && w_not_full;
  assign w_rd_data   = r_mem[r_rptr];
  assign w_next_beat = r_beat + 8'd1;

  // Bytes actually taken from the FIFO for this message; the rest is padding.
  // When level < KK it is below 256, so the low byte is the whole value.
  assign w_real = (r_level >= KK_L) ? KK_B : r_level[7:0];

  // A message starts only from IDLE with the encoder free and enough data,
  // or with a pending flush and at least one byte to send.
  assign w_start = (r_state == IDLE) && !enc_busy &&
                   ((r_level >= KK_L) || (r_flush_pend && (r_level != '0)));

  // In SEND, the beat being loaded pops only while it is still a real byte.
  assign w_pop_send = (r_state == SEND) && (r_beat != LAST_BEAT) &&
                      (w_next_beat < r_real);

  // The first beat always pops because real >= 1 whenever a message starts.
  assign w_rd = w_start || w_pop_send;

  // FIFO storage write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= s_data;
  end

  // FIFO pointers and occupancy; simultaneous write and read keep level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Message FSM with registered encoder outputs and flush bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_real       <= '0;
      r_flush_pend <= 1'b0;
      r_din_val    <= 1'b0;
      r_din_sop    <= 1'b0;
      r_din_eop    <= 1'b0;
      r_din        <= '0;
      r_msg_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state      <= SEND;
            r_beat       <= '0;
            r_real       <= w_real;
            r_flush_pend <= 1'b0;
            r_din_val    <= 1'b1;
            r_din_sop    <= 1'b1;
            r_din_eop    <= (LAST_BEAT == 8'd0);
            r_din        <= w_rd_data;
          end else if (r_flush_pend && (r_level == '0)) begin
            // Flush with nothing buffered: drop it, send nothing.
            r_flush_pend <= 1'b0;
          end
        end
        SEND: begin
          if (r_beat == LAST_BEAT) begin
            r_state   <= GAP;
            r_din_val <= 1'b0;
            r_din_sop <= 1'b0;
            r_din_eop <= 1'b0;
            r_msg_cnt <= r_msg_cnt + 16'd1;
          end else begin
            r_beat    <= w_next_beat;
            r_din_sop <= 1'b0;
            r_din_eop <= (w_next_beat == LAST_BEAT);
            r_din     <= (w_next_beat < r_real) ? w_rd_data : PAD_BYTE;
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // A new flush request is never lost, even on the cycle pend is cleared.
      if (flush) r_flush_pend <= 1'b1;
    end
  end

  assign s_ready   = w_not_full;
  assign din_val   = r_din_val;
  assign din_sop   = r_din_sop;
  assign din_eop   = r_din_eop;
  assign din       = r_din;
  assign level     = r_level;
  assign msg_cnt   = r_msg_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rs_msg_framer.sv
// Directed bench for rs_msg_framer: bytes written (and pads implied by a
// flush) are pushed to an expected queue; a negedge monitor pops and checks
// every encoder beat plus sop/eop placement and burst spacing.
`define CHK(tag, obs, exp) \
  begin \
    n_tests++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h, expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_rs_msg_framer;

  localparam int         KK  = 251;
  localparam int         AW  = 9;
  localparam logic [7:0] PAD = 8'h00;

  logic          clk;
  logic          rst_n;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          flush;
  logic          enc_busy;
  logic          din_val;
  logic          din_sop;
  logic          din_eop;
  logic [7:0]    din;
  logic [AW:0]   level;
  logic [15:0]   msg_cnt;
  logic [1:0]    dbg_state;

  rs_msg_framer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .flush     (flush),
    .enc_busy  (enc_busy),
    .din_val   (din_val),
    .din_sop   (din_sop),
    .din_eop   (din_eop),
    .din       (din),
    .level     (level),
    .msg_cnt   (msg_cnt),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  logic [7:0] exp_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   n_beats   = 0;
  int   n_bursts  = 0;
  int   mon_beat  = 0;
  int   sop_cyc   = 0;
  int   eop_cyc   = 0;
  bit   have_eop  = 0;
  int   min_gap   = 1000000;
  int   wr_cyc    = 0;
  int   stall_cnt = 0;
  logic [7:0] last_din = 8'h00;

  // Monitor: every valid beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_beat = 0;
      last_din = 8'h00;
    end else if (din_val) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL din_extra: observed %0h, expected no beat", din);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        `CHK("din", din, e)
      end
      `CHK("din_sop", din_sop, (mon_beat == 0))
      `CHK("din_eop", din_eop, (mon_beat == KK - 1))
      if (mon_beat == 0) begin
        sop_cyc = cyc;
        n_bursts++;
        if (have_eop && (cyc - eop_cyc) < min_gap) min_gap = cyc - eop_cyc;
      end
      if (mon_beat == KK - 1) begin
        eop_cyc  = cyc;
        have_eop = 1;
        mon_beat = 0;
      end else begin
        mon_beat++;
      end
      n_beats++;
      last_din = din;
    end else begin
      `CHK("din_hold", din, last_din)
    end
  end

  // Driver: offer one byte, wait up to max_wait cycles for s_ready.
  task automatic write_byte(input logic [7:0] b, input int max_wait, output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    stall_cnt += w;
    if (s_ready) begin
      wr_cyc = cyc;
      exp_q.push_back(b);
      @(posedge clk);
      ok = 1;
    end else begin
      s_valid = 1'b0;
      ok = 0;
    end
  endtask

  task automatic write_seq(input logic [7:0] start, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      write_byte(8'(start + 8'(i)), 2000, ok);
      if (!ok) `CHK("write_accept", ok, 1'b1)
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_flush(input int n_pads);
    @(negedge clk);
    flush = 1'b1;
    for (int i = 0; i < n_pads; i++) exp_q.push_back(PAD);
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Wait until the expected queue is down to target and the FSM is idle.
  task automatic wait_drain(input int target);
    int t;
    t = 0;
    while (!(exp_q.size() == target && dbg_state == 2'd0) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    `CHK("drain_in_time", (t < 4000), 1'b1)
  endtask

  int   exp_msgs = 0;
  int   nb;
  int   rel_cyc;
  int   burst_base;
  bit   ok;

  initial begin
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    flush    = 1'b0;
    enc_busy = 1'b0;
    repeat (2) @(negedge clk);
    `CHK("rst_din_val", din_val, 1'b0)
    `CHK("rst_din_sop", din_sop, 1'b0)
    `CHK("rst_din_eop", din_eop, 1'b0)
    `CHK("rst_din", din, 8'h00)
    `CHK("rst_level", level, 10'd0)
    `CHK("rst_msg_cnt", msg_cnt, 16'd0)
    `CHK("rst_state", dbg_state, 2'd0)
    `CHK("rst_s_ready", s_ready, 1'b1)
    @(negedge clk);
    rst_n = 1'b1;

    // One full message 0..250, latency from the KK-th write to sop.
    nb = n_beats;
    write_seq(8'h00, KK);
    wait_drain(0);
    exp_msgs++;
    `CHK("t1_msg_cnt", msg_cnt, 16'(exp_msgs))
    `CHK("t1_level", level, 10'd0)
    `CHK("t1_beats", n_beats - nb, KK)
    `CHK("t1_latency", sop_cyc - wr_cyc, 2)

    // Flush on an empty FIFO sends nothing.
    nb = n_beats;
    pulse_flush(0);
    repeat (10) @(negedge clk);
    `CHK("fe_no_beats", n_beats - nb, 0)
    `CHK("fe_state", dbg_state, 2'd0)

    // Partial message 0..99 padded by flush.
    write_seq(8'h00, 100);
    pulse_flush(KK - 100);
    wait_drain(0);
    exp_msgs++;
    `CHK("t2_msg_cnt", msg_cnt, 16'(exp_msgs))
    `CHK("t2_level", level, 10'd0)

    // Encoder busy holds the message back; sop one cycle after release.
    @(negedge clk);
    enc_busy = 1'b1;
    write_seq(8'h40, KK);
    nb = n_beats;
    repeat (20) @(negedge clk);
    `CHK("t3_no_beats_busy", n_beats - nb, 0)
    enc_busy = 1'b0;
    rel_cyc  = cyc;
    wait_drain(0);
    exp_msgs++;
    `CHK("t3_sop_after_release", sop_cyc - rel_cyc, 1)
    `CHK("t3_msg_cnt", msg_cnt, 16'(exp_msgs))

    // Fill to DEPTH while busy; s_ready drops; two messages drain, 10 left.
    @(negedge clk);
    enc_busy = 1'b1;
    write_seq(8'h00, 512);
    `CHK("t4_level_full", level, 10'd512)
    `CHK("t4_s_ready_low", s_ready, 1'b0)
    write_byte(8'hAA, 5, ok);
    `CHK("t4_reject_when_full", ok, 1'b0)
    @(negedge clk);
    enc_busy = 1'b0;
    wait_drain(10);
    exp_msgs += 2;
    `CHK("t4_msg_cnt", msg_cnt, 16'(exp_msgs))
    `CHK("t4_level_left", level, 10'd10)

    // Flush the 10 leftovers.
    pulse_flush(KK - 10);
    wait_drain(0);
    exp_msgs++;
    `CHK("t4f_level", level, 10'd0)
    `CHK("t4f_msg_cnt", msg_cnt, 16'(exp_msgs))

    // Continuous stream of 502 bytes: two bursts, no backpressure.
    stall_cnt  = 0;
    have_eop   = 0;
    min_gap    = 1000000;
    burst_base = n_bursts;
    write_seq(8'h10, 2 * KK);
    wait_drain(0);
    exp_msgs += 2;
    `CHK("t5_no_stall", stall_cnt, 0)
    `CHK("t5_bursts", n_bursts - burst_base, 2)
    `CHK("t5_gap_ge_2", (min_gap >= 2), 1'b1)
    `CHK("t5_msg_cnt", msg_cnt, 16'(exp_msgs))
    `CHK("t5_level", level, 10'd0)

    // Reset in the middle of a burst (beat 100).
    nb = n_beats;
    write_seq(8'h80, KK);
    begin
      int t;
      t = 0;
      while (n_beats != nb + 100 && t < 1000) begin
        @(posedge clk);
        t++;
      end
      `CHK("t6_reach_beat100", (t < 1000), 1'b1)
    end
    #1;
    `CHK("t6_mid_burst_val", din_val, 1'b1)
    rst_n = 1'b0;
    #1;
    `CHK("t6_rst_din_val", din_val, 1'b0)
    `CHK("t6_rst_din_sop", din_sop, 1'b0)
    `CHK("t6_rst_din_eop", din_eop, 1'b0)
    `CHK("t6_rst_din", din, 8'h00)
    `CHK("t6_rst_level", level, 10'd0)
    `CHK("t6_rst_msg_cnt", msg_cnt, 16'd0)
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nb = n_beats;
    repeat (20) @(negedge clk);
    `CHK("t6_no_beats_after", n_beats - nb, 0)
    `CHK("t6_state_idle", dbg_state, 2'd0)
    `CHK("t6_level_after", level, 10'd0)
    `CHK("t6_s_ready_after", s_ready, 1'b1)

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
